// File: rtl/softmax_dma_sched.sv
// softmax_dma_sched
//   Batch scheduler for the softmax DMA path. A rising edge of the GPIO
//   command word (0xAA) starts a run of NUM_BATCH batches. Each batch issues
//   one MM2S read command and one S2MM write command, then waits for both
//   DataMover status bytes and BEATS_PER_BATCH result beats.
//
// Ports
//   clk, rstn               clock, asynchronous active-low reset
//   gpio_io_o               command word: 0xAA start (edge), 0x0 abort/clear
//   gpio_io_i               status: [0] busy [1] done [2] err [7:4] batch
//                           [15:8] failing status byte
//   m_axis_{mm2s,s2mm}_cmd_*  72-bit DataMover command streams
//   s_axis_{mm2s,s2mm}_sts_*  8-bit DataMover status streams
//   result_beat             one S2MM result beat accepted this cycle
//   m_axis_s2mm_tlast       high while the next result beat ends its batch
//
// Handshake rule: a transfer happens on a rising clk edge where tvalid and
// tready are both high; command tvalid/tdata never change while waiting for
// tready, and no tvalid or tready here depends combinationally on its peer.
module softmax_dma_sched #(
  parameter int unsigned NUM_BATCH       = 4,
  parameter int unsigned MM2S_BTT        = 312000,
  parameter int unsigned S2MM_BTT        = 19200,
  parameter logic [31:0] MM2S_BASE       = 32'h0000_0000,
  parameter logic [31:0] S2MM_BASE       = 32'h0008_0000,
  parameter int unsigned BEATS_PER_BATCH = 4800
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] gpio_io_o,
  output logic [31:0] gpio_io_i,
  output logic        m_axis_mm2s_cmd_tvalid,
  input  logic        m_axis_mm2s_cmd_tready,
  output logic [71:0] m_axis_mm2s_cmd_tdata,
  output logic        m_axis_s2mm_cmd_tvalid,
  input  logic        m_axis_s2mm_cmd_tready,
  output logic [71:0] m_axis_s2mm_cmd_tdata,
  input  logic        s_axis_mm2s_sts_tvalid,
  input  logic [7:0]  s_axis_mm2s_sts_tdata,
  output logic        s_axis_mm2s_sts_tready,
  input  logic        s_axis_s2mm_sts_tvalid,
  input  logic [7:0]  s_axis_s2mm_sts_tdata,
  output logic        s_axis_s2mm_sts_tready,
  input  logic        result_beat,
  output logic        m_axis_s2mm_tlast
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_t;

  localparam logic [12:0] BEATS      = 13'(BEATS_PER_BATCH);
  localparam logic [12:0] BEATS_M1   = BEATS - 13'd1;
  localparam logic [3:0]  LAST_BATCH = 4'(NUM_BATCH - 1);

  // Command layout: {4'0, tag, saddr, DRR=1, EOF=1, DSA=0, INCR=1, BTT}
  function automatic logic [71:0] make_cmd(input logic [22:0] btt,
                                           input logic [31:0] addr,
                                           input logic [3:0]  tag);
    return {4'h0, tag, addr, 1'b1, 1'b1, 6'h00, 1'b1, btt};
  endfunction

  function automatic logic sts_bad(input logic [7:0] sts, input logic [3:0] tag);
    return !sts[7] || (|sts[6:4]) || (sts[3:0] != tag);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  batch_q, batch_d;
  logic [12:0] beat_cnt_q, beat_cnt_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [7:0]  fail_q, fail_d;
  logic        mm_vld_q, mm_vld_d, s2_vld_q, s2_vld_d;
  logic        mm_acc_q, mm_acc_d, s2_acc_q, s2_acc_d;
  logic        mm_got_q, mm_got_d, s2_got_q, s2_got_d;
  logic        start_prev_q, start_prev_d;
  logic        tlast_q, tlast_d;

  logic start_hit, start_edge, abort;
  logic mm_sts_rdy, s2_sts_rdy, mm_sts_fire, s2_sts_fire;

  assign start_hit   = (gpio_io_o == 32'h0000_00AA);
  assign start_edge  = start_hit && !start_prev_q;
  assign abort       = (gpio_io_o == 32'h0000_0000);
  assign mm_sts_rdy  = (state_q == S_WAIT) && !mm_got_q;
  assign s2_sts_rdy  = (state_q == S_WAIT) && !s2_got_q;
  assign mm_sts_fire = mm_sts_rdy && s_axis_mm2s_sts_tvalid;
  assign s2_sts_fire = s2_sts_rdy && s_axis_s2mm_sts_tvalid;

  assign s_axis_mm2s_sts_tready = mm_sts_rdy;
  assign s_axis_s2mm_sts_tready = s2_sts_rdy;
  assign m_axis_mm2s_cmd_tvalid = mm_vld_q;
  assign m_axis_s2mm_cmd_tvalid = s2_vld_q;
  assign m_axis_mm2s_cmd_tdata  = make_cmd(23'(MM2S_BTT),
                                           MM2S_BASE + 32'(batch_q) * 32'(MM2S_BTT), batch_q);
  assign m_axis_s2mm_cmd_tdata  = make_cmd(23'(S2MM_BTT),
                                           S2MM_BASE + 32'(batch_q) * 32'(S2MM_BTT), batch_q);
  assign m_axis_s2mm_tlast      = tlast_q;
  assign gpio_io_i = {16'h0000, fail_q, batch_q, 1'b0, err_q, done_q, busy_q};

  always_comb begin
    state_d      = state_q;
    batch_d      = batch_q;
    beat_cnt_d   = beat_cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    fail_d       = fail_q;
    mm_vld_d     = mm_vld_q;
    s2_vld_d     = s2_vld_q;
    mm_acc_d     = mm_acc_q;
    s2_acc_d     = s2_acc_q;
    mm_got_d     = mm_got_q;
    s2_got_d     = s2_got_q;
    start_prev_d = start_hit;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          state_d    = S_ISSUE;
          batch_d    = 4'd0;
          beat_cnt_d = 13'd0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          fail_d     = 8'h00;
          mm_vld_d   = 1'b1;
          s2_vld_d   = 1'b1;
          mm_acc_d   = 1'b0;
          s2_acc_d   = 1'b0;
          mm_got_d   = 1'b0;
          s2_got_d   = 1'b0;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (mm_vld_q && m_axis_mm2s_cmd_tready) begin
          mm_vld_d = 1'b0;
          mm_acc_d = 1'b1;
        end
        if (s2_vld_q && m_axis_s2mm_cmd_tready) begin
          s2_vld_d = 1'b0;
          s2_acc_d = 1'b1;
        end
        if (mm_sts_fire) mm_got_d = 1'b1;
        if (s2_sts_fire) s2_got_d = 1'b1;
        if (result_beat && (beat_cnt_q != BEATS)) beat_cnt_d = beat_cnt_q + 13'd1;
        if ((state_q == S_ISSUE) && mm_acc_d && s2_acc_d) state_d = S_WAIT;

        // Errors outrank completion; MM2S is reported when both fail at once.
        if ((mm_sts_fire && sts_bad(s_axis_mm2s_sts_tdata, batch_q)) ||
            (s2_sts_fire && sts_bad(s_axis_s2mm_sts_tdata, batch_q)) ||
            (result_beat && (beat_cnt_q == BEATS))) begin
          state_d  = S_ERR;
          busy_d   = 1'b0;
          err_d    = 1'b1;
          mm_vld_d = 1'b0;
          s2_vld_d = 1'b0;
          if (mm_sts_fire && sts_bad(s_axis_mm2s_sts_tdata, batch_q))
            fail_d = s_axis_mm2s_sts_tdata;
          else if (s2_sts_fire && sts_bad(s_axis_s2mm_sts_tdata, batch_q))
            fail_d = s_axis_s2mm_sts_tdata;
        end else if ((state_q == S_WAIT) && mm_got_d && s2_got_d && (beat_cnt_d == BEATS)) begin
          if (batch_q == LAST_BATCH) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d    = S_ISSUE;
            batch_d    = batch_q + 4'd1;
            beat_cnt_d = 13'd0;
            mm_vld_d   = 1'b1;
            s2_vld_d   = 1'b1;
            mm_acc_d   = 1'b0;
            s2_acc_d   = 1'b0;
            mm_got_d   = 1'b0;
            s2_got_d   = 1'b0;
          end
        end
      end
      default: ;  // S_ERR holds until abort
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      batch_d    = 4'd0;
      beat_cnt_d = 13'd0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      fail_d     = 8'h00;
      mm_vld_d   = 1'b0;
      s2_vld_d   = 1'b0;
      mm_acc_d   = 1'b0;
      s2_acc_d   = 1'b0;
      mm_got_d   = 1'b0;
      s2_got_d   = 1'b0;
    end

    // Registered from the next count so tlast lines up with the last beat.
    tlast_d = (beat_cnt_d == BEATS_M1) && ((state_d == S_ISSUE) || (state_d == S_WAIT));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      batch_q      <= 4'd0;
      beat_cnt_q   <= 13'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      fail_q       <= 8'h00;
      mm_vld_q     <= 1'b0;
      s2_vld_q     <= 1'b0;
      mm_acc_q     <= 1'b0;
      s2_acc_q     <= 1'b0;
      mm_got_q     <= 1'b0;
      s2_got_q     <= 1'b0;
      // Treated as already seen, so a level-held 0xAA cannot start a run
      // straight out of reset.
      start_prev_q <= 1'b1;
      tlast_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      batch_q      <= batch_d;
      beat_cnt_q   <= beat_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      fail_q       <= fail_d;
      mm_vld_q     <= mm_vld_d;
      s2_vld_q     <= s2_vld_d;
      mm_acc_q     <= mm_acc_d;
      s2_acc_q     <= s2_acc_d;
      mm_got_q     <= mm_got_d;
      s2_got_q     <= s2_got_d;
      start_prev_q <= start_prev_d;
      tlast_q      <= tlast_d;
    end
  end

endmodule

// File: doc/softmax_dma_sched.md
Name: softmax_dma_sched

Overview:
Batch scheduler for the softmax DMA path. It is started from the GPIO command word and sequences NUM_BATCH back-to-back DataMover transfers. Each transfer is one MM2S read command (input vectors) plus one S2MM write command (results), with per-batch address stepping. The block also counts result beats to generate the S2MM tlast, checks the DataMover status streams, and reports busy/done/error through the GPIO input word.

Parameters:
NUM_BATCH, 4, number of batches per run (1..16)
MM2S_BTT, 312000, bytes per MM2S command (23-bit field)
S2MM_BTT, 19200, bytes per S2MM command (23-bit field)
MM2S_BASE, 32'h0000_0000, MM2S start address for batch 0
S2MM_BASE, 32'h0008_0000, S2MM start address for batch 0
BEATS_PER_BATCH, 4800, 32-bit result beats per batch

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
gpio_io_o  in  32  command word: 32'hAA = start, 32'h0 = abort/clear
gpio_io_i  out  32  status: [0] busy, [1] done, [2] err, [7:4] current batch, [15:8] failing status byte, others 0
m_axis_mm2s_cmd_tvalid  out  1  MM2S command valid
m_axis_mm2s_cmd_tready  in  1  MM2S command ready
m_axis_mm2s_cmd_tdata  out  72  MM2S command
m_axis_s2mm_cmd_tvalid  out  1  S2MM command valid
m_axis_s2mm_cmd_tready  in  1  S2MM command ready
m_axis_s2mm_cmd_tdata  out  72  S2MM command
s_axis_mm2s_sts_tvalid  in  1  MM2S status valid
s_axis_mm2s_sts_tdata  in  8  MM2S status: [3:0] tag, [4] INTERR, [5] DECERR, [6] SLVERR, [7] OKAY
s_axis_mm2s_sts_tready  out  1  MM2S status ready
s_axis_s2mm_sts_tvalid  in  1  S2MM status valid
s_axis_s2mm_sts_tdata  in  8  S2MM status, same layout
s_axis_s2mm_sts_tready  out  1  S2MM status ready
result_beat  in  1  one result beat accepted this cycle (s2mm tvalid & tready)
m_axis_s2mm_tlast  out  1  high while the next result beat is the last of its batch

Behaviour:
- Reset (async assert, sync release): state IDLE; all tvalid/tready outputs 0; gpio_io_i = 0; batch = 0; beat_cnt = 0; tlast = 0.
- Start: rising edge of (gpio_io_o == 32'hAA), i.e. registered previous compare was false. Level-held 0xAA never restarts a run. Start is accepted only in IDLE or DONE.
- Abort: gpio_io_o == 0 forces IDLE from any state at the next edge. It clears batch, beat_cnt, done, err and drops all tvalids. Abort has priority over every other event.
- Command tdata (both channels):
  - [22:0] BTT
  - [23] = 1
  - [29:24] = 0
  - [30] = 1
  - [31] = 1
  - [63:32] = BASE + batch*BTT (32-bit, wraps modulo 2^32)
  - [67:64] = batch[3:0]
  - [71:68] = 0
  - tdata is stable while tvalid is high.
- FSM:
  - IDLE -> ISSUE on start. Sets busy = 1, done = 0, err = 0.
  - ISSUE: both cmd tvalids rise in the cycle after entry. Each channel drops its tvalid the cycle after its own tvalid & tready. The channels handshake independently, in either order or in the same cycle. When both are accepted -> WAIT.
  - WAIT: both sts treadys = 1 until that channel's status is captured, then 0. The batch completes when both statuses are captured AND beat_cnt == BEATS_PER_BATCH.
    - Status error: OKAY = 0, any of bits [6:4] set, or tag != batch[3:0]. The failing byte goes to gpio_io_i[15:8]; -> ERR. If both statuses fail in the same cycle, record MM2S.
    - Completion with batch == NUM_BATCH-1 -> DONE; otherwise batch++ and beat_cnt = 0 -> ISSUE.
  - DONE: busy = 0, done = 1. Holds until abort or a new start.
  - ERR: busy = 0, err = 1. All tvalids and treadys are 0. Only abort exits.
- beat_cnt: 13-bit; increments on result_beat in ISSUE or WAIT. It saturates at BEATS_PER_BATCH, and extra beats set err -> ERR. result_beat is ignored in IDLE, DONE and ERR.
- m_axis_s2mm_tlast = (beat_cnt == BEATS_PER_BATCH-1) and state is ISSUE or WAIT. It is registered from the next-count value, so it is valid in the same cycle the last beat is presented.
- Status arriving before the commands are both accepted is illegal. sts tready stays 0 in ISSUE.

Test Plan:
- NUM_BATCH = 2, ready always 1, OKAY status with the correct tags, 4800 beats per batch. Required: 2 command pairs; MM2S SADDR 0x0 then 0x4C2C0; S2MM SADDR 0x80000 then 0x84B00; tags 0 then 1; tlast high exactly on beats 4799 and 9599; gpio_io_i = 0x12 at the end (done = 1, batch = 1).
- MM2S cmd_tready held low for 10 cycles while S2MM is ready. Required: S2MM tvalid is a 1-cycle handshake; MM2S tvalid and tdata stay stable for 10 cycles; no status tready before both commands are accepted.
- S2MM status 0x40 | tag (SLVERR) in batch 0. Required: ERR state, gpio_io_i[2] = 1, [15:8] = 0x40, no further commands; gpio_io_o = 0 then returns gpio_io_i to 0.
- gpio_io_o held at 0xAA across the DONE state. Required: no second run. Writing 0x55 then 0xAA starts a new run with batch = 0.
- Abort (gpio_io_o = 0) mid-WAIT after 2000 beats, then restart. Required: cmd tvalids 0 next cycle; beat_cnt reset; the first tlast of the new run arrives on beat 4799.
- rstn pulsed low mid-ISSUE, asynchronously and not clock-aligned. Required: all outputs 0 immediately; no command is issued after release until a fresh 0xAA edge.
